// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve slice.
// Holds the RV32I branch funct3 encodings and the 2-bit BHT counter
// states. It also holds a log2 helper that sizes the BHT index field
// from the entry count.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  // Smallest r with 2**r >= n; the BHT index width for n entries.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Indexed table of 2-bit saturating branch counters.
// Ports:
//   clk, rst_n      : clock, async active-low reset (all entries -> WNT)
//   rd_idx, rd_cnt  : combinational read port (value before any same-edge write)
//   wr_en, wr_idx,
//   wr_taken        : training port; counts up on taken, down on not-taken
module bht_2bit
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = log2_ceil(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_cnt_t table_q [ENTRIES];

  // The read is a plain array access, so a write on the coming edge
  // is not visible until after that edge.
  assign rd_cnt = table_q[rd_idx];

  // Counters move one step toward ST or SNT and stick at the ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= WNT;
    end else if (wr_en) begin
      if (wr_taken && (table_q[wr_idx] != ST))
        table_q[wr_idx] <= bht_cnt_t'(table_q[wr_idx] + 2'd1);
      else if (!wr_taken && (table_q[wr_idx] != SNT))
        table_q[wr_idx] <= bht_cnt_t'(table_q[wr_idx] - 2'd1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage resolution of RV32I control transfers.
// It computes the direction, target, link and redirect PC for BEQ..BGEU,
// JAL and JALR. It compares them with the fetch prediction and registers
// the result for the EX/MEM boundary. It trains a 2-bit BHT, and fetch
// reads that BHT through a combinational lookup port.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   valid_in, branch_in, jump_in,
//   jalr_in, funct3_in               : instruction qualifiers (jalr > jal > branch)
//   rs1_data, rs2_data, immediate,
//   current_pc                       : operands and PC of the EX instruction
//   pred_taken_in, pred_target_in    : fetch prediction being checked
//   stall_in, flush_in               : hold / kill (flush wins)
//   lookup_pc_in, lookup_taken_out   : BHT read for fetch
//   *_out                            : registered result and statistics
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             branch_in,
  input  logic             jump_in,
  input  logic             jalr_in,
  input  logic [2:0]       funct3_in,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  immediate,
  input  logic [XLEN-1:0]  current_pc,
  input  logic             pred_taken_in,
  input  logic [XLEN-1:0]  pred_target_in,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic [XLEN-1:0]  lookup_pc_in,
  output logic             lookup_taken_out,
  output logic             valid_out,
  output logic             branch_taken_out,
  output logic [XLEN-1:0]  branch_target_out,
  output logic [XLEN-1:0]  link_addr_out,
  output logic [XLEN-1:0]  redirect_pc_out,
  output logic             mispredict_out,
  output logic             illegal_out,
  output logic             misaligned_out,
  output logic [CNT_W-1:0] branch_count_out,
  output logic [CNT_W-1:0] mispredict_count_out
);

  localparam int IDX_W = log2_ceil(BHT_ENTRIES);

  logic            is_jalr, is_jal, is_br, is_ctrl;
  logic            cond, bad_f3, illegal, taken, misaligned, mispredict;
  logic [XLEN-1:0] pc_target, jalr_sum, target, link, redirect;
  logic            advance, bht_wr;
  logic [1:0]      lookup_cnt;
  logic            pc_bits_unused;

  assign is_jalr = jalr_in;
  assign is_jal  = jump_in & ~jalr_in;
  assign is_br   = branch_in & ~jump_in & ~jalr_in;
  assign is_ctrl = jalr_in | jump_in | branch_in;

  // Branch condition by funct3. The two unassigned encodings (010/011)
  // flag the branch as illegal and leave it not taken.
  always_comb begin
    cond   = 1'b0;
    bad_f3 = 1'b0;
    case (funct3_in)
      F3_BEQ:  cond = (rs1_data == rs2_data);
      F3_BNE:  cond = (rs1_data != rs2_data);
      F3_BLT:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: cond = (rs1_data <  rs2_data);
      F3_BGEU: cond = (rs1_data >= rs2_data);
      default: bad_f3 = 1'b1;
    endcase
  end

  assign illegal   = is_br & bad_f3;
  assign taken     = is_jalr | is_jal | (is_br & cond & ~bad_f3);
  assign pc_target = current_pc + immediate;
  assign jalr_sum  = rs1_data + immediate;
  assign target    = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_target;
  assign link      = current_pc + XLEN'(4);
  assign redirect  = taken ? target : link;

  // A misaligned taken target goes to trap logic, so it never also
  // raises a mispredict redirect.
  assign misaligned = taken & target[1];
  assign mispredict = ~misaligned &
                      ((taken != pred_taken_in) | (taken & (target != pred_target_in)));

  assign advance = ~flush_in & ~stall_in & valid_in;
  assign bht_wr  = advance & is_br & ~bad_f3;

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (lookup_pc_in[IDX_LSB +: IDX_W]),
    .rd_cnt   (lookup_cnt),
    .wr_en    (bht_wr),
    .wr_idx   (current_pc[IDX_LSB +: IDX_W]),
    .wr_taken (taken)
  );

  assign lookup_taken_out = lookup_cnt[1];

  // PC bits outside the index field carry no meaning for the BHT.
  assign pc_bits_unused = ^{lookup_pc_in, current_pc};

  // EX/MEM result register. A flush kills the slot and clears its flags.
  // A stall freezes everything. Flags are qualified by valid_in so an
  // empty slot never reports a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out         <= 1'b0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
      link_addr_out     <= '0;
      redirect_pc_out   <= '0;
      mispredict_out    <= 1'b0;
      illegal_out       <= 1'b0;
      misaligned_out    <= 1'b0;
    end else if (flush_in) begin
      valid_out        <= 1'b0;
      branch_taken_out <= 1'b0;
      mispredict_out   <= 1'b0;
      illegal_out      <= 1'b0;
      misaligned_out   <= 1'b0;
    end else if (!stall_in) begin
      valid_out         <= valid_in;
      branch_taken_out  <= valid_in & taken;
      branch_target_out <= target;
      link_addr_out     <= link;
      redirect_pc_out   <= redirect;
      mispredict_out    <= valid_in & mispredict;
      illegal_out       <= valid_in & illegal;
      misaligned_out    <= valid_in & misaligned;
    end
  end

  // Statistics only see control transfers that actually retire from EX.
  // Both counters stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_out     <= '0;
      mispredict_count_out <= '0;
    end else if (advance && is_ctrl) begin
      if (branch_count_out != '1)
        branch_count_out <= branch_count_out + CNT_W'(1);
      if (mispredict && (mispredict_count_out != '1))
        mispredict_count_out <= mispredict_count_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit.
// It drives hand-computed vectors and checks every observation with an
// immediate assertion. Outputs are sampled 1 ns after the rising edge,
// and the lookup port is sampled before the edge.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_in, branch_in, jump_in, jalr_in;
  logic [2:0]  funct3_in;
  logic [31:0] rs1_data, rs2_data, immediate, current_pc;
  logic        pred_taken_in;
  logic [31:0] pred_target_in;
  logic        stall_in, flush_in;
  logic [31:0] lookup_pc_in;
  logic        lookup_taken_out;
  logic        valid_out, branch_taken_out;
  logic [31:0] branch_target_out, link_addr_out, redirect_pc_out;
  logic        mispredict_out, illegal_out, misaligned_out;
  logic [31:0] branch_count_out, mispredict_count_out;

  int checks_total;
  int checks_passed;

  branch_resolve_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .valid_in             (valid_in),
    .branch_in            (branch_in),
    .jump_in              (jump_in),
    .jalr_in              (jalr_in),
    .funct3_in            (funct3_in),
    .rs1_data             (rs1_data),
    .rs2_data             (rs2_data),
    .immediate            (immediate),
    .current_pc           (current_pc),
    .pred_taken_in        (pred_taken_in),
    .pred_target_in       (pred_target_in),
    .stall_in             (stall_in),
    .flush_in             (flush_in),
    .lookup_pc_in         (lookup_pc_in),
    .lookup_taken_out     (lookup_taken_out),
    .valid_out            (valid_out),
    .branch_taken_out     (branch_taken_out),
    .branch_target_out    (branch_target_out),
    .link_addr_out        (link_addr_out),
    .redirect_pc_out      (redirect_pc_out),
    .mispredict_out       (mispredict_out),
    .illegal_out          (illegal_out),
    .misaligned_out       (misaligned_out),
    .branch_count_out     (branch_count_out),
    .mispredict_count_out (mispredict_count_out)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one EX-stage instruction.
  // kind: 0 none, 1 branch, 2 jal, 3 jalr, 4 branch+jal
  task automatic applyStimulus(input logic v, input int kind, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic pt, input logic [31:0] ptgt,
                               input logic st, input logic fl);
    valid_in       = v;
    branch_in      = (kind == 1) || (kind == 4);
    jump_in        = (kind == 2) || (kind == 4);
    jalr_in        = (kind == 3);
    funct3_in      = f3;
    rs1_data       = a;
    rs2_data       = b;
    immediate      = imm;
    current_pc     = pc;
    pred_taken_in  = pt;
    pred_target_in = ptgt;
    stall_in       = st;
    flush_in       = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n         = 1'b0;
    lookup_pc_in  = 32'h100;
    applyStimulus(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    checkOutput("rst_valid", {31'b0, valid_out}, 32'd0);
    checkOutput("rst_redirect", redirect_pc_out, 32'd0);
    checkOutput("rst_mispredict", {31'b0, mispredict_out}, 32'd0);
    checkOutput("rst_bcount", branch_count_out, 32'd0);
    checkOutput("rst_lookup", {31'b0, lookup_taken_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, predicted not taken; BHT[0] goes 01 -> 10
    applyStimulus(1, 1, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 0, 32'h0, 0, 0);
    lookup_pc_in = 32'h100;
    #1 checkOutput("beq_lookup_pre", {31'b0, lookup_taken_out}, 32'd0);
    tick();
    checkOutput("beq_valid", {31'b0, valid_out}, 32'd1);
    checkOutput("beq_taken", {31'b0, branch_taken_out}, 32'd1);
    checkOutput("beq_target", branch_target_out, 32'h120);
    checkOutput("beq_redirect", redirect_pc_out, 32'h120);
    checkOutput("beq_link", link_addr_out, 32'h104);
    checkOutput("beq_mispredict", {31'b0, mispredict_out}, 32'd1);
    checkOutput("beq_bcount", branch_count_out, 32'd1);
    checkOutput("beq_mcount", mispredict_count_out, 32'd1);
    checkOutput("beq_lookup_post", {31'b0, lookup_taken_out}, 32'd1);

    // BLT signed: -1 < 1, taken, prediction correct
    applyStimulus(1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1, 32'h240, 0, 0);
    tick();
    checkOutput("blt_taken", {31'b0, branch_taken_out}, 32'd1);
    checkOutput("blt_target", branch_target_out, 32'h240);
    checkOutput("blt_mispredict", {31'b0, mispredict_out}, 32'd0);

    // BLTU: 0xFFFFFFFF < 1 is false
    applyStimulus(1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1, 32'h240, 0, 0);
    tick();
    checkOutput("bltu_taken", {31'b0, branch_taken_out}, 32'd0);
    checkOutput("bltu_redirect", redirect_pc_out, 32'h204);
    checkOutput("bltu_mispredict", {31'b0, mispredict_out}, 32'd1);
    checkOutput("bltu_mcount", mispredict_count_out, 32'd2);

    // JALR: (0x1003+4)&~1 = 0x1006, misaligned, mispredict suppressed
    lookup_pc_in = 32'h304;
    applyStimulus(1, 3, 3'b000, 32'h1003, 32'd0, 32'd4, 32'h304, 1, 32'h1006, 0, 0);
    tick();
    checkOutput("jalr_target", branch_target_out, 32'h1006);
    checkOutput("jalr_link", link_addr_out, 32'h308);
    checkOutput("jalr_taken", {31'b0, branch_taken_out}, 32'd1);
    checkOutput("jalr_misaligned", {31'b0, misaligned_out}, 32'd1);
    checkOutput("jalr_mispredict", {31'b0, mispredict_out}, 32'd0);
    checkOutput("jalr_bht_untouched", {31'b0, lookup_taken_out}, 32'd0);
    checkOutput("jalr_bcount", branch_count_out, 32'd4);
    checkOutput("jalr_mcount", mispredict_count_out, 32'd2);

    // Four taken BEQs at 0x108: 01->10->11->11
    lookup_pc_in = 32'h108;
    applyStimulus(1, 1, 3'b000, 32'd7, 32'd7, 32'h10, 32'h108, 1, 32'h118, 0, 0);
    #1 checkOutput("sat_lookup_pre", {31'b0, lookup_taken_out}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("sat_lookup_step", {31'b0, lookup_taken_out}, 32'd1);
    end
    checkOutput("sat_mispredict", {31'b0, mispredict_out}, 32'd0);
    checkOutput("sat_bcount", branch_count_out, 32'd8);

    // Two not-taken BEQs: 11->10 (MSB 1) then 10->01 (MSB 0)
    applyStimulus(1, 1, 3'b000, 32'd7, 32'd8, 32'h10, 32'h108, 0, 32'h0, 0, 0);
    tick();
    checkOutput("nt1_lookup", {31'b0, lookup_taken_out}, 32'd1);
    checkOutput("nt1_redirect", redirect_pc_out, 32'h10C);
    checkOutput("nt1_mispredict", {31'b0, mispredict_out}, 32'd0);
    tick();
    checkOutput("nt2_lookup", {31'b0, lookup_taken_out}, 32'd0);
    checkOutput("nt2_bcount", branch_count_out, 32'd10);

    // Flush together with stall: slot killed, nothing trained or counted
    lookup_pc_in = 32'h10C;
    applyStimulus(1, 1, 3'b000, 32'd3, 32'd3, 32'h10, 32'h10C, 0, 32'h0, 1, 1);
    tick();
    checkOutput("flush_valid", {31'b0, valid_out}, 32'd0);
    checkOutput("flush_bcount", branch_count_out, 32'd10);
    checkOutput("flush_mcount", mispredict_count_out, 32'd2);
    checkOutput("flush_lookup", {31'b0, lookup_taken_out}, 32'd0);

    // BNE taken, mispredicted, then three stalled cycles holding it
    applyStimulus(1, 1, 3'b001, 32'd1, 32'd2, 32'h8, 32'h400, 0, 32'h0, 0, 0);
    tick();
    checkOutput("bne_target", branch_target_out, 32'h408);
    checkOutput("bne_mcount", mispredict_count_out, 32'd3);
    applyStimulus(1, 1, 3'b000, 32'd3, 32'd3, 32'h10, 32'h10C, 1, 32'h11C, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_valid", {31'b0, valid_out}, 32'd1);
      checkOutput("stall_target", branch_target_out, 32'h408);
      checkOutput("stall_mispredict", {31'b0, mispredict_out}, 32'd1);
      checkOutput("stall_bcount", branch_count_out, 32'd11);
    end
    checkOutput("stall_lookup", {31'b0, lookup_taken_out}, 32'd0);

    // Illegal funct3 010 on a branch
    applyStimulus(1, 1, 3'b010, 32'd9, 32'd9, 32'h10, 32'h110, 0, 32'h0, 0, 0);
    tick();
    checkOutput("ill_flag", {31'b0, illegal_out}, 32'd1);
    checkOutput("ill_taken", {31'b0, branch_taken_out}, 32'd0);
    checkOutput("ill_bcount", branch_count_out, 32'd12);

    // Non-control instruction with a taken prediction
    applyStimulus(1, 0, 3'b000, 32'd0, 32'd0, 32'd0, 32'h500, 1, 32'h600, 0, 0);
    tick();
    checkOutput("nc_valid", {31'b0, valid_out}, 32'd1);
    checkOutput("nc_taken", {31'b0, branch_taken_out}, 32'd0);
    checkOutput("nc_mispredict", {31'b0, mispredict_out}, 32'd1);
    checkOutput("nc_bcount", branch_count_out, 32'd12);
    checkOutput("nc_illegal", {31'b0, illegal_out}, 32'd0);

    // JAL beats a not-taken BNE; target wraps past 2^32
    applyStimulus(1, 4, 3'b001, 32'd4, 32'd4, 32'h20, 32'hFFFF_FFF0, 1, 32'h10, 0, 0);
    tick();
    checkOutput("jal_taken", {31'b0, branch_taken_out}, 32'd1);
    checkOutput("jal_target", branch_target_out, 32'h10);
    checkOutput("jal_link", link_addr_out, 32'hFFFF_FFF4);
    checkOutput("jal_mispredict", {31'b0, mispredict_out}, 32'd0);
    checkOutput("jal_bcount", branch_count_out, 32'd13);

    // Asynchronous reset mid-stream
    lookup_pc_in = 32'h100;
    #1 checkOutput("pre_rst_lookup", {31'b0, lookup_taken_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'b0, valid_out}, 32'd0);
    checkOutput("arst_target", branch_target_out, 32'd0);
    checkOutput("arst_bcount", branch_count_out, 32'd0);
    checkOutput("arst_mcount", mispredict_count_out, 32'd0);
    checkOutput("arst_lookup", {31'b0, lookup_taken_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh start after reset
    applyStimulus(1, 1, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 0, 32'h0, 0, 0);
    tick();
    checkOutput("fresh_valid", {31'b0, valid_out}, 32'd1);
    checkOutput("fresh_bcount", branch_count_out, 32'd1);
    checkOutput("fresh_lookup", {31'b0, lookup_taken_out}, 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
